port_source: RTL
================

Name: port_source

Overview:
- Stimulus generator that drives a sequence of TIS words into one port of a core or row.
- Acts as the writer end of the core port handshake, mirroring the existing sink (reader).
- Loads a fixed value list and presents each value in turn, holding it until the consumer acknowledges.
- Reports progress and completion to the bench or the top-level FPGA test harness.

Parameters:
- DEPTH, 39, maximum number of words in the sequence.
- LOOP, 0, when 1, wraps to index 0 after the last word instead of finishing.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins streaming from index 0
- len  input  $clog2(DEPTH+1)  number of valid words in seq (0..DEPTH)
- seq  input  11 x [0:DEPTH-1]  unpacked array of signed words to send
- write  output  1  word valid; connects to the consumer's rready
- out  output  11  signed word being offered
- wready  input  1  consumer accept; connects to the consumer's read
- count  output  8  number of words accepted since start, saturates at 255
- busy  output  1  high while in SEND
- done  output  1  sticky high after the last word is accepted (LOOP=0)

Behaviour:
- Reset (rst high at a posedge, takes priority over everything): state=IDLE, write=0, out=0, count=0, busy=0, done=0, index=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - start=1 and len>0 -> SEND, index=0, done=0, count=0. write=1 and out=clamp(seq[0]) from the next cycle.
  - start=1 and len=0 -> DONE directly, done=1, write never asserted.
- SEND:
  - write=1; out is stable and unchanged until accepted.
  - An accept is wready=1 at a posedge while write=1.
  - On accept: count+=1 (saturate at 255).
    - If index<len-1: index+=1 and out=clamp(seq[index+1]) in the same edge. Back-to-back transfers allow one word per cycle.
    - If index=len-1 and LOOP=0: -> DONE, write=0, done=1.
    - If index=len-1 and LOOP=1: index=0 and out=clamp(seq[0]); stays in SEND.
  - wready while write=0 is ignored.
  - start while in SEND is ignored.
- DONE: write=0, out holds the last word, done=1. start restarts exactly as from IDLE.
- busy = (state==SEND).
- Clamp rule: words are interpreted as 11-bit two's complement.
  - Values >999 are sent as 999.
  - Values <-999 are sent as -999.
  - Example: 11'h400 (-1024) is sent as -999 (11'h419).
- len is sampled only at start. len>DEPTH is treated as DEPTH.
- seq is read combinationally at the index; the bench must hold it stable while busy.
- Reset asserted mid-transfer aborts immediately: write drops on the same edge and no partial count is kept.

Decomposition:
- Package tis_pkg holds:
  - WORD_W=11
  - TIS_MAX=999, TIS_MIN=-999
  - typedef logic signed [WORD_W-1:0] tis_word_t
  - enum src_state_t {IDLE, SEND, DONE}
  - function tis_clamp(tis_word_t) returning tis_word_t
- No sub-module. The clamp function is shared with the sink and the core ALU saturation.

Test Plan:
- Reset for 2 cycles, then observe with no start: write=0, out=0, count=0, done=0, busy=0 for 10 cycles.
- seq={5,-3,999}, len=3, start pulse, wready held 1: out = 5, -3, 999 on consecutive cycles; done=1 one cycle after the third accept; count=3.
- Same sequence with wready asserted only every 4th cycle: each value held stable for exactly 4 cycles with write=1; done asserts after the 3rd accept; count=3.
- seq={1200,-1024,0}, len=3: accepted values are 999, -999, 0.
- LOOP=1, seq={7,8}, len=2, wready=1 for 6 cycles: out = 7,8,7,8,7,8; count=6; done stays 0.
- rst pulsed after the 2nd of 3 accepts: write=0 and count=0 on the following cycle. A new start then resends from seq[0].
- len=0 with start: done=1 the next cycle, write never rises.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared TIS word definitions: word width, saturation limits, the clamp
// helper and the port_source state encoding.
package tis_pkg;

   localparam int WORD_W = 11;

   typedef logic signed [WORD_W-1:0] tis_word_t;

   localparam tis_word_t TIS_MAX = 11'sd999;
   localparam tis_word_t TIS_MIN = -11'sd999;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } src_state_t;

   // Saturate a two's complement word into the TIS range [-999, 999].
   function automatic tis_word_t tis_clamp(input tis_word_t w);
      if (w > TIS_MAX) begin
         return TIS_MAX;
      end else if (w < TIS_MIN) begin
         return TIS_MIN;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/port_source.sv
// Writer end of the core port handshake: streams a fixed list of TIS words,
// one per accept, and reports progress (count) and completion (done).
//
// Handshake: write marks out as valid. A word is transferred on any rising
// edge where write=1 and wready=1; out is held unchanged until then. wready
// seen while write=0 has no effect. write never depends combinationally on
// wready, so the consumer may tie wready high.
module port_source
   import tis_pkg::*;
#(
   parameter int DEPTH = 39,
   parameter bit LOOP  = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(DEPTH+1)-1:0] len,
   input  tis_word_t                  seq [0:DEPTH-1],
   output logic                       write,
   output tis_word_t                  out,
   input  logic                       wready,
   output logic [7:0]                 count,
   output logic                       busy,
   output logic                       done
);

   localparam int LEN_W = $clog2(DEPTH+1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   src_state_t       state;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] next_index;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_eff;
   logic             last;

   // Length limiting, next position and end-of-list detection.
   always_comb begin
      len_eff    = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
      next_index = index + IDX_W'(1);
      last       = (LEN_W'(index) == (len_q - LEN_W'(1)));
   end

   assign busy  = (state == SEND);
   assign write = busy;

   // Sequencer: start loads the list, each accept advances it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out   <= '0;
         count <= '0;
         done  <= 1'b0;
         index <= '0;
         len_q <= '0;
      end else begin
         case (state)
            SEND: begin
               if (wready) begin
                  if (count != 8'hFF) begin
                     count <= count + 8'd1;
                  end
                  if (!last) begin
                     index <= next_index;
                     out   <= tis_clamp(seq[next_index]);
                  end else if (LOOP) begin
                     index <= '0;
                     out   <= tis_clamp(seq[0]);
                  end else begin
                     // out keeps showing the final word after completion
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               // IDLE and DONE restart identically
               if (start) begin
                  count <= '0;
                  index <= '0;
                  len_q <= len_eff;
                  if (len_eff != '0) begin
                     state <= SEND;
                     done  <= 1'b0;
                     out   <= tis_clamp(seq[0]);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
